// File: rtl/ippcrc_pkg.sv
// ippcrc_pkg: shared polynomial constants, FSM state type and width helper for the ippcrc blocks
package ippcrc_pkg;

    localparam logic [11:0] CRC12       = 12'h80F;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32       = 32'h04C11DB7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/ippcrc_step8.sv
// ippcrc_step8: combinational one-byte CRC step, byte bit 0 enters the register first
module ippcrc_step8
    import ippcrc_pkg::*;
#(
    parameter int            CW   = 12,
    parameter logic [CW-1:0] POLY = CW'(CRC12)
) (
    input  logic [CW-1:0] crc_i,
    input  logic [7:0]    dat_i,
    output logic [CW-1:0] crc_o
);

    // shift eight data bits through the register, feeding back POLY on each MSB carry
    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++) crc_o = {crc_o[CW-2:0], 1'b0} ^ ({CW{crc_o[CW-1] ^ dat_i[i]}} & POLY);
    end

endmodule

// File: rtl/ippcrc_stream.sv
// ippcrc_stream: frame-aware streaming CRC engine; IPPCRC_STREAM_CHECK_EN adds FCS compare (fcs_i/res_ok)
module ippcrc_stream
    import ippcrc_pkg::*;
#(
    parameter int            CW     = 12,
    parameter int            DW     = 64,
    parameter logic [CW-1:0] POLY   = CW'(CRC12),
    parameter logic [CW-1:0] INIT   = '0,
    parameter logic [CW-1:0] XOROUT = '0,
    localparam int           NB     = DW / 8,
    localparam int           NBW    = clog2(NB) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic           in_sop,
    input  logic           in_eop,
    input  logic [NBW-1:0] in_nb,
    input  logic [DW-1:0]  in_dat,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [CW-1:0]  res_crc,
    output logic           err_nosop
`ifdef IPPCRC_STREAM_CHECK_EN
    ,
    input  logic [CW-1:0]  fcs_i,
    output logic           res_ok
`endif
);

    state_e        state_q, state_d, eff;
    logic [CW-1:0] crc_q, crc_d, res_crc_q, res_crc_d, crc_upd;
    logic          err_q, err_d, acc, take, ok_q, ok_d;
    logic [CW-1:0] tap [NB+1];

    assign in_rdy    = (state_q != DONE) | res_rdy;
    assign acc       = in_vld & in_rdy;
    assign tap[0]    = in_sop ? INIT : crc_q;
    assign res_vld   = state_q == DONE;
    assign res_crc   = res_crc_q;
    assign err_nosop = err_q;

    for (genvar g = 0; g < NB; g++) begin : g_step
        ippcrc_step8 #(.CW(CW), .POLY(POLY)) u_step (
            .crc_i(tap[g]),
            .dat_i(in_dat[8*g +: 8]),
            .crc_o(tap[g+1])
        );
    end

    // a partial eop beat takes the tap after in_nb bytes, otherwise the full cascade
    always_comb begin
        crc_upd = tap[NB];
        for (int k = 1; k < NB; k++) crc_upd = (in_eop && in_nb == NBW'(k)) ? tap[k] : crc_upd;
    end

    // a result being accepted frees the engine in the same cycle, so a new sop can follow at full rate
    always_comb begin
        eff       = (state_q == DONE && res_rdy) ? IDLE : state_q;
        take      = acc && (in_sop || eff == BUSY);
        err_d     = acc && !take;
        state_d   = take ? (in_eop ? DONE : BUSY) : eff;
        crc_d     = take ? crc_upd : crc_q;
        res_crc_d = (take && in_eop) ? crc_upd ^ XOROUT : res_crc_q;
`ifdef IPPCRC_STREAM_CHECK_EN
        ok_d      = (take && in_eop) ? ((crc_upd ^ XOROUT) == fcs_i) : ok_q;
`else
        ok_d      = 1'b0;
`endif
    end

    // state, running CRC and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            res_crc_q <= '0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            res_crc_q <= res_crc_d;
            err_q     <= err_d;
            ok_q      <= ok_d;
        end
    end

`ifdef IPPCRC_STREAM_CHECK_EN
    assign res_ok = ok_q;
`else
    logic unused_ok;
    assign unused_ok = ok_q;
`endif

endmodule

// File: tb/tb_ippcrc_stream.sv
// tb_ippcrc_stream: randomized and directed checks of ippcrc_stream against a polynomial long-division model
module tb_ippcrc_stream;

    localparam logic [11:0] P = 12'h80F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, res_rdy = 1'b1;
    logic [3:0]  in_nb = 4'd8;
    logic [63:0] in_dat = '0;
    logic [11:0] fcs = '0;
    logic        rdy0, vld0, err0, rdy1, vld1, err1;
    logic        ok0 = 1'b0, ok1 = 1'b0;
    logic [11:0] crc0, crc1;

    int n_tests = 0, n_fail = 0;
    int hold = 0;
    bit rand_rdy = 0;
    bit open = 0, done = 0, exp_err = 0, acc_q = 0;
    logic [11:0] exp0 = '0, exp1 = '0;
    logic        exp_ok0 = 1'b0, exp_ok1 = 1'b0;
    logic [7:0]  fb[$];

    always #5 clk = ~clk;

    ippcrc_stream d0 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy0), .in_sop(in_sop), .in_eop(in_eop),
        .in_nb(in_nb), .in_dat(in_dat), .res_vld(vld0), .res_rdy(res_rdy), .res_crc(crc0), .err_nosop(err0)
`ifdef IPPCRC_STREAM_CHECK_EN
        , .fcs_i(fcs), .res_ok(ok0)
`endif
    );

    ippcrc_stream #(.XOROUT(12'hFFF)) d1 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy1), .in_sop(in_sop), .in_eop(in_eop),
        .in_nb(in_nb), .in_dat(in_dat), .res_vld(vld1), .res_rdy(res_rdy), .res_crc(crc1), .err_nosop(err1)
`ifdef IPPCRC_STREAM_CHECK_EN
        , .fcs_i(fcs), .res_ok(ok1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // remainder of M(x)*x^12 mod G(x), wire bit order = descending polynomial degree
    function automatic logic [11:0] crc_ref(input logic [7:0] b[$]);
        bit m[$];
        int len;
        logic [11:0] r;
        foreach (b[i]) for (int j = 0; j < 8; j++) m.push_back(b[i][j]);
        len = m.size();
        for (int j = 0; j < 12; j++) m.push_back(1'b0);
        for (int i = 0; i < len; i++) if (m[i]) for (int j = 1; j <= 12; j++) m[i+j] ^= P[12-j];
        for (int j = 0; j < 12; j++) r[11-j] = m[len+j];
        return r;
    endfunction

    task automatic tick();
        bit exp_rdy, nerr;
        res_rdy = (hold > 0) ? 1'b0 : (rand_rdy ? 1'($urandom % 2) : 1'b1);
        if (hold > 0) hold--;
        #1;
        exp_rdy = !done || res_rdy;
        check("in_rdy", 32'(rdy0), 32'(exp_rdy));
        check("in_rdy_x", 32'(rdy1), 32'(exp_rdy));
        check("err_nosop", 32'(err0), 32'(exp_err));
        check("res_vld", 32'(vld0), 32'(done));
        check("res_vld_x", 32'(vld1), 32'(done));
        if (done) begin
            check("res_crc", 32'(crc0), 32'(exp0));
            check("res_crc_x", 32'(crc1), 32'(exp1));
`ifdef IPPCRC_STREAM_CHECK_EN
            check("res_ok", 32'(ok0), 32'(exp_ok0));
            check("res_ok_x", 32'(ok1), 32'(exp_ok1));
`endif
        end
        if (done && res_rdy) done = 0;
        acc_q = in_vld && exp_rdy;
        nerr = 0;
        if (acc_q) begin
            if (in_sop) begin
                fb.delete();
                open = 1;
            end
            if (!open) nerr = 1;
            else begin
                for (int k = 0; k < (in_eop ? int'(in_nb) : 8); k++) fb.push_back(in_dat[8*k +: 8]);
                if (in_eop) begin
                    exp0 = crc_ref(fb);
                    exp1 = exp0 ^ 12'hFFF;
                    exp_ok0 = exp0 == fcs;
                    exp_ok1 = exp1 == fcs;
                    done = 1;
                    open = 0;
                end
            end
        end
        exp_err = nerr;
        @(negedge clk);
    endtask

    task automatic send(input bit sop, input bit eop, input int nb, input logic [63:0] dat);
        int n = 0;
        in_vld = 1'b1;
        in_sop = sop;
        in_eop = eop;
        in_nb  = 4'(nb);
        in_dat = dat;
        do begin
            tick();
            n++;
        end while (!acc_q && n < 100);
        if (!acc_q) check("accept_timeout", 32'(acc_q), 32'd1);
        in_vld = 1'b0;
    endtask

    task automatic do_reset();
        in_vld = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_res_vld", 32'(vld0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_crc", 32'(crc0), 32'd0);
        open = 0;
        done = 0;
        exp_err = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, runs=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        do_reset();
        repeat (5) tick();

        fcs = 12'hD05;
        send(1, 1, 1, 64'h1);
        #1;
        check("bit0_vld", 32'(vld0), 32'd1);
        check("bit0_crc", 32'(crc0), 32'hD05);
        check("bit0_crc_x", 32'(crc1), 32'h2FA);
`ifdef IPPCRC_STREAM_CHECK_EN
        check("bit0_ok", 32'(ok0), 32'd1);
        tick();
        fcs = 12'hD04;
        send(1, 1, 1, 64'h1);
        #1;
        check("bit0_nok", 32'(ok0), 32'd0);
`endif
        tick();

        send(1, 0, 8, '0);
        send(0, 0, 8, '0);
        send(0, 1, 8, '0);
        #1;
        check("zero_crc", 32'(crc0), 32'h000);
        check("zero_crc_x", 32'(crc1), 32'hFFF);
        tick();

        hold = 6;
        send(1, 0, 8, {$urandom, $urandom});
        send(0, 1, 5, {$urandom, $urandom});
        send(1, 1, 1, 64'h1);
        #1;
        check("stall_b_crc", 32'(crc0), 32'hD05);
        repeat (2) tick();

        send(0, 1, 3, {$urandom, $urandom});
        send(0, 0, 8, {$urandom, $urandom});
        repeat (2) tick();

        send(1, 0, 8, {$urandom, $urandom});
        send(1, 0, 8, {$urandom, $urandom});
        send(0, 1, 8, {$urandom, $urandom});
        tick();

        send(1, 0, 8, {$urandom, $urandom});
        do_reset();
        repeat (3) tick();
        send(0, 1, 8, {$urandom, $urandom});
        repeat (2) tick();

        rand_rdy = 1;
        for (int f = 0; f < 150; f++) begin
            int nbeats = $urandom_range(1, 4);
            if ($urandom % 10 == 0) send(0, $urandom % 2, $urandom_range(1, 8), {$urandom, $urandom});
            fcs = 12'($urandom);
            for (int b = 0; b < nbeats; b++) begin
                if (b > 0 && $urandom % 15 == 0) send(1, 0, 8, {$urandom, $urandom});
                send(b == 0, b == nbeats - 1, $urandom_range(1, 8), {$urandom, $urandom});
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_rdy = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
